// File: rtl/fsm_serv_burst_if.sv
// Bus bundle of the burst sequencer: CPU-side start/len/address controls in,
// SPI memory bus cycle signals and burst status out.
interface fsm_serv_burst_if #(
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 24
);
    logic              i_start;
    logic              i_cpu_reset;
    logic [LEN_W-1:0]  i_len;
    logic [ADDR_W-1:0] i_base_adr;
    logic              i_ack;
    logic              o_out_cyc;
    logic [ADDR_W-1:0] o_adr;
    logic              o_enable;
    logic [LEN_W-1:0]  o_beat;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_start, i_cpu_reset, i_len, i_base_adr, i_ack,
        input  o_out_cyc, o_adr, o_enable, o_beat, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_cpu_reset, i_len, i_base_adr, i_ack,
        output o_out_cyc, o_adr, o_enable, o_beat, o_busy, o_done, o_err
    );
endinterface

// File: rtl/fsm_serv_burst.sv
// Burst bus sequencer: runs i_len+1 acked bus beats with auto-incrementing address.
// Optional REQ watchdog enabled by defining FSM_SERV_BURST_WDOG_EN.
module fsm_serv_burst #(
    parameter int LEN_W     = 4,
    parameter int ADDR_W    = 24,
    parameter int ADDR_STEP = 4,
    parameter int TMO_CYC   = 255
) (
    input  logic             clk,
    input  logic             rst,
    fsm_serv_burst_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [LEN_W-1:0]  r_beat;
    logic [LEN_W-1:0]  w_beat_nxt;
    logic [ADDR_W-1:0] r_adr;
    logic [ADDR_W-1:0] w_adr_nxt;
    logic              r_out_cyc;
    logic              r_enable;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_timeout;

`ifdef FSM_SERV_BURST_WDOG_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] r_tmo;

    // Counter idles at zero outside REQ, so every REQ entry starts a fresh count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo <= '0;
        end else if (r_state != S_REQ) begin
            r_tmo <= '0;
        end else if (!bus.i_ack) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_REQ) && !bus.i_ack &&
                       (r_tmo == TMO_W'(TMO_CYC - 1));
`else
    // TMO_CYC has no effect without the watchdog
    assign w_timeout = 1'b0 && (TMO_CYC > 0);
`endif

    always_comb begin
        w_next     = r_state;
        w_len_nxt  = r_len;
        w_adr_nxt  = r_adr;
        w_beat_nxt = r_beat;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start && bus.i_cpu_reset) begin
                    w_next     = S_REQ;
                    w_len_nxt  = bus.i_len;
                    w_adr_nxt  = bus.i_base_adr;
                    w_beat_nxt = '0;
                end
            end
            S_REQ: begin
                if (!bus.i_cpu_reset) begin
                    w_next = S_IDLE;
                end else if (bus.i_ack) begin
                    w_next = S_LOAD;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_LOAD: begin
                if (!bus.i_cpu_reset) begin
                    w_next = S_IDLE;
                end else if (r_beat != r_len) begin
                    w_next     = S_REQ;
                    w_beat_nxt = r_beat + LEN_W'(1);
                    w_adr_nxt  = r_adr + ADDR_W'(ADDR_STEP);
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Address and beat read as zero whenever the sequencer is idle
        if (w_next == S_IDLE) begin
            w_adr_nxt  = '0;
            w_beat_nxt = '0;
        end
    end

    assign w_err_nxt = (r_state == S_REQ) && (w_next == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_adr     <= '0;
            r_beat    <= '0;
            r_out_cyc <= 1'b0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_len     <= w_len_nxt;
            r_adr     <= w_adr_nxt;
            r_beat    <= w_beat_nxt;
            r_out_cyc <= (w_next == S_REQ);
            r_enable  <= (w_next == S_LOAD);
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (w_next == S_DONE);
            r_err     <= w_err_nxt;
        end
    end

    assign bus.o_out_cyc = r_out_cyc;
    assign bus.o_adr     = r_adr;
    assign bus.o_enable  = r_enable;
    assign bus.o_beat    = r_beat;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_err     = r_err;

endmodule
